// File: rtl/dekatron_pulse_receiver.sv
// Counting-dekatron model: filters the {Right, Left} guide pulse pair, walks the glow
// across the guide electrodes and reports cathode steps, wraps and bad patterns.
module dekatron_pulse_receiver #(
   parameter int CATHODES  = 10,
   parameter int MIN_WIDTH = 2,
   parameter int RESET_POS = 0
) (
   input  logic                        hsClk,
   input  logic                        Rst,
   input  logic [1:0]                  Pulses,
   input  logic                        Clear,
   output logic [CATHODES-1:0]         Out,
   output logic [$clog2(CATHODES)-1:0] Num,
   output logic                        Step,
   output logic                        Dir,
   output logic                        Carry,
   output logic                        Borrow,
   output logic                        Error
);

   localparam int                 NW       = $clog2(CATHODES);
   localparam logic [NW-1:0]       LAST_NUM = NW'(CATHODES - 1);
   localparam logic [NW-1:0]       RST_NUM  = NW'(RESET_POS);
   localparam logic [CATHODES-1:0] ONE_HOT  = CATHODES'(1);
   localparam logic [CATHODES-1:0] RST_OUT  = ONE_HOT << RESET_POS;
   localparam logic [2:0]          MIN_RUN  = 3'(MIN_WIDTH);

   localparam logic [2:0] CATH = 3'd0;
   localparam logic [2:0] GL1  = 3'd1;
   localparam logic [2:0] GR2  = 3'd2;
   localparam logic [2:0] GR1  = 3'd3;
   localparam logic [2:0] GL2  = 3'd4;

   logic [1:0]    pulsesQ;
   logic [2:0]    run;
   logic          qualDone;
   logic [2:0]    state;
   logic [2:0]    stateNext;
   logic          fwdStep;
   logic          revStep;
   logic          fsmErr;
   logic          isWrap;
   logic [NW-1:0] numNext;
   logic          qualified;
   logic          newQual;
   logic          glitch;

   assign qualified = (run == MIN_RUN);
   // qualDone marks that the held pattern was already acted on, so 11 reports only once.
   assign newQual   = qualified && !qualDone;
   assign glitch    = (Pulses != pulsesQ) && (pulsesQ != 2'b00) && (run < MIN_RUN);

   always_ff @(posedge hsClk or posedge Rst) begin
      // NOTE: registered state uses non-blocking assignments so every flop sees pre-edge values.
      if (Rst) begin
         pulsesQ  <= 2'b00;
         run      <= 3'd0;
         qualDone <= 1'b0;
      end else begin
         pulsesQ  <= Pulses;
         if (Pulses == pulsesQ) begin
            run <= qualified ? MIN_RUN : run + 3'd1;
         end else begin
            run <= 3'd1;
         end
         qualDone <= qualified && (Pulses == pulsesQ);
      end
   end

   always_comb begin
      // NOTE: defaults ahead of the case keep every path assigned, so no latches are inferred.
      stateNext = state;
      fwdStep   = 1'b0;
      revStep   = 1'b0;
      fsmErr    = 1'b0;
      if (qualified) begin
         case (state)
            CATH: begin
               case (pulsesQ)
                  2'b01:   stateNext = GL1;
                  2'b10:   stateNext = GR1;
                  2'b11:   fsmErr    = newQual;
                  default: ;
               endcase
            end
            GL1: begin
               case (pulsesQ)
                  2'b00:        stateNext = CATH;
                  2'b10, 2'b11: stateNext = GR2;
                  default:      ;
               endcase
            end
            GR2: begin
               case (pulsesQ)
                  2'b00: begin
                     stateNext = CATH;
                     fwdStep   = 1'b1;
                  end
                  2'b01: begin
                     stateNext = GL1;
                     fwdStep   = 1'b1;
                  end
                  default: ;
               endcase
            end
            GR1: begin
               case (pulsesQ)
                  2'b00:        stateNext = CATH;
                  2'b01, 2'b11: stateNext = GL2;
                  default:      ;
               endcase
            end
            GL2: begin
               case (pulsesQ)
                  2'b00: begin
                     stateNext = CATH;
                     revStep   = 1'b1;
                  end
                  2'b10: begin
                     stateNext = GR1;
                     revStep   = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: stateNext = CATH;
         endcase
      end
   end

   always_comb begin
      numNext = Num;
      isWrap  = 1'b0;
      if (fwdStep) begin
         isWrap  = (Num == LAST_NUM);
         numNext = isWrap ? '0 : Num + NW'(1);
      end else if (revStep) begin
         isWrap  = (Num == '0);
         numNext = isWrap ? LAST_NUM : Num - NW'(1);
      end
   end

   // Clear overrides the tube side only; the input filter above keeps running.
   always_ff @(posedge hsClk or posedge Rst) begin
      if (Rst) begin
         state  <= CATH;
         Num    <= RST_NUM;
         Out    <= RST_OUT;
         Step   <= 1'b0;
         Dir    <= 1'b0;
         Carry  <= 1'b0;
         Borrow <= 1'b0;
         Error  <= 1'b0;
      end else if (Clear) begin
         state  <= CATH;
         Num    <= RST_NUM;
         Out    <= RST_OUT;
         Step   <= 1'b0;
         Carry  <= 1'b0;
         Borrow <= 1'b0;
         Error  <= glitch;
      end else begin
         state  <= stateNext;
         Num    <= numNext;
         Out    <= ONE_HOT << numNext;
         Step   <= fwdStep | revStep;
         Carry  <= fwdStep & isWrap;
         Borrow <= revStep & isWrap;
         Error  <= glitch | fsmErr;
         if (fwdStep || revStep) begin
            Dir <= revStep;
         end
      end
   end

endmodule
